out_capture_fifo: RTL and testbench

OUT_CAPTURE_FIFO -- requirements
Module: out_capture_fifo

---
 rtl/out_capture_fifo.sv | 140 ++++++++++++++
 tb/tb_out_capture_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/out_capture_fifo.sv
// Capture FIFO for {out0, bus_out} samples with a first-word fall-through read side and sticky overflow.
// Optional push gating on change of sample word: define OUT_CAPTURE_CHANGE_DETECT_EN.
module out_capture_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          out0,
  input  logic [1:0]    bus_out,
  input  logic          sample_en,
  input  logic          rd_ready,
  input  logic          ovf_clr,
  output logic          rd_valid,
  output logic [2:0]    rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("out_capture_fifo: DEPTH must be a power of two between 2 and 16");
  end
  if (CW != AW + 1) begin : g_bad_cw
    $error("out_capture_fifo: CW must equal log2(DEPTH)+1");
  end

  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [DEPTH-1:0] wr_en;

  logic [2:0] sample_word;
  logic       push_req;
  logic       pop;
  logic       push_acc;
  logic       drop;

  assign sample_word = {out0, bus_out};

`ifdef OUT_CAPTURE_CHANGE_DETECT_EN
  logic [2:0] last_word_q;
  logic       first_flag_q;

  // Only a word that actually enters storage becomes the new comparison reference.
  assign push_req = sample_en && (first_flag_q || (sample_word != last_word_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_word_q  <= 3'b000;
      first_flag_q <= 1'b1;
    end else if (push_acc) begin
      last_word_q  <= sample_word;
      first_flag_q <= 1'b0;
    end
  end
`else
  assign push_req = sample_en;
`endif

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign rd_valid = !empty;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_data  = mem_q[rd_ptr_q];

  assign pop      = rd_valid && rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_acc = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_acc) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A new drop wins over a clear in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push_acc && (wr_ptr_q == AW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 3'b000;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          mem_q[i] <= sample_word;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_out_capture_fifo.sv
// Directed scoreboard bench for out_capture_fifo (DEPTH=4): stimulus queues expected words,
// a negedge monitor checks every word popped by the consumer.
module tb_out_capture_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       out0;
  logic [1:0] bus_out;
  logic       sample_en;
  logic       rd_ready;
  logic       ovf_clr;
  logic       rd_valid;
  logic [2:0] rd_data;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  int checks = 0;
  int passes = 0;
  int pop_cnt = 0;
  int pops_before;
  int exp_pops;
  logic [2:0] exp_q[$];
  logic [2:0] mon_exp;

  out_capture_fifo #(.DEPTH(4), .CW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .out0      (out0),
    .bus_out   (bus_out),
    .sample_en (sample_en),
    .rd_ready  (rd_ready),
    .ovf_clr   (ovf_clr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passes++;
      $display("check %-20s got %0d expected %0d ok", nm, act, exp);
    end else begin
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Apply one cycle of stimulus; 'acc' says whether the word is expected to enter storage.
  task automatic step(input logic en, input logic [2:0] w, input logic rdy,
                      input logic clr, input bit acc);
    sample_en = en;
    {out0, bus_out} = w;
    rd_ready = rdy;
    ovf_clr = clr;
    if (en && acc) exp_q.push_back(w);
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    {out0, bus_out} = 3'b000;
    rd_ready = 1'b0;
    ovf_clr = 1'b0;
  endtask

  // Monitor: inputs are stable at the falling edge, so a pop seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      checks++;
      pop_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected: got %0b expected no word", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data === mon_exp) begin
          passes++;
          $display("pop word got %03b expected %03b ok", rd_data, mon_exp);
        end else begin
          $display("FAIL pop_word: got %03b expected %03b", rd_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    sample_en = 1'b0;
    {out0, bus_out} = 3'b000;
    rd_ready = 1'b0;
    ovf_clr = 1'b0;
    #12;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two pushes, then two pops
    step(1'b1, 3'b101, 1'b0, 1'b0, 1'b1);
    chk("first_fwft_data", int'(rd_data), 5);
    step(1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
    chk("two_push_count", int'(count), 2);
    chk("two_push_head", int'(rd_data), 5);
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("after_pop1_data", int'(rd_data), 2);
    chk("after_pop1_count", int'(count), 1);
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("after_pop2_empty", int'(empty), 1);

    // Fill, drop the fifth, drain
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b011, 1'b0, 1'b0, 1'b1);
    chk("three_full", int'(full), 0);
    step(1'b1, 3'b100, 1'b0, 1'b0, 1'b1);
    chk("four_full", int'(full), 1);
    chk("four_count", int'(count), 4);
    chk("four_overflow", int'(overflow), 0);
    step(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
    chk("drop_overflow", int'(overflow), 1);
    chk("drop_count", int'(count), 4);
    chk("drop_head", int'(rd_data), 1);
    for (int i = 0; i < 4; i++) step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("drain_empty", int'(empty), 1);
    chk("ovf_sticky", int'(overflow), 1);

    // Overflow clear, then clear coinciding with a drop
    step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
    chk("ovf_cleared", int'(overflow), 0);
    step(1'b1, 3'b110, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b110, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b001, 1'b0, 1'b0, 1'b1);
    chk("refill_full", int'(full), 1);
    step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    chk("ovf_set_again", int'(overflow), 1);
    step(1'b1, 3'b011, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr_with_drop", int'(overflow), 1);
    step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
    chk("ovf_cleared2", int'(overflow), 0);

    // Push and pop together while full
    step(1'b1, 3'b111, 1'b1, 1'b0, 1'b1);
    chk("full_pushpop_count", int'(count), 4);
    chk("full_pushpop_ovf", int'(overflow), 0);
    chk("full_pushpop_full", int'(full), 1);
    chk("full_pushpop_head", int'(rd_data), 1);
    for (int i = 0; i < 4; i++) step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("drain2_empty", int'(empty), 1);

    // Asynchronous reset with three entries stored
    step(1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b101, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_count", int'(count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_empty", int'(empty), 1);
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_valid", int'(rd_valid), 0);
    chk("async_rst_data", int'(rd_data), 0);
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    step(1'b1, 3'b011, 1'b0, 1'b0, 1'b1);
    chk("post_rst_count", int'(count), 1);
    chk("post_rst_data", int'(rd_data), 3);
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("post_rst_empty", int'(empty), 1);

    // Held sample_en with repeated word, consumer always ready
    pops_before = pop_cnt;
`ifdef OUT_CAPTURE_CHANGE_DETECT_EN
    step(1'b1, 3'b110, 1'b1, 1'b0, 1'b1);
    step(1'b1, 3'b110, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'b110, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'b110, 1'b1, 1'b0, 1'b0);
    exp_pops = 2;
`else
    step(1'b1, 3'b110, 1'b1, 1'b0, 1'b1);
    step(1'b1, 3'b110, 1'b1, 1'b0, 1'b1);
    step(1'b1, 3'b110, 1'b1, 1'b0, 1'b1);
    step(1'b1, 3'b110, 1'b1, 1'b0, 1'b1);
    exp_pops = 5;
`endif
    step(1'b1, 3'b011, 1'b1, 1'b0, 1'b1);
    step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("stream_empty", int'(empty), 1);
    chk("stream_entries", pop_cnt - pops_before, exp_pops);

    @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
